// File: rtl/sume_reset_pkg.sv
// ============================================================
// sume_reset_pkg: state encodings and default timing constants
// Revision: 1.0
// ============================================================
`default_nettype none

package sume_reset_pkg;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_REL_CORE = 3'd1,
    ST_REL_MAC  = 3'd2,
    ST_RUN      = 3'd3,
    ST_FAULT    = 3'd4
  } seq_state_e;

  localparam int DEF_HOLD_CYCLES  = 200;
  localparam int DEF_STAGE_GAP    = 16;
  localparam int DEF_DEBOUNCE     = 4;
  localparam int DEF_LOCK_TIMEOUT = 1048576;
  localparam int DEF_CNT_W        = 8;

endpackage

`default_nettype wire

// File: rtl/sume_rst_debounce.sv
// ============================================================
// sume_rst_debounce: consecutive-high filter
// Revision: 1.0
// ============================================================
`default_nettype none

module sume_rst_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  // cnt holds the number of prior consecutive high cycles, saturating at
  // DEBOUNCE-1, so dout asserts on the edge sampling the DEBOUNCE-th high.
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !din) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign dout = din && (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/sume_reset_sequencer.sv
// ============================================================
// sume_reset_sequencer: ordered core/MAC/datapath reset release
// Revision: 1.0
// ============================================================
`default_nettype none

module sume_reset_sequencer
  import sume_reset_pkg::*;
#(
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int STAGE_GAP    = DEF_STAGE_GAP,
  parameter int DEBOUNCE     = DEF_DEBOUNCE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             axis_aclk,
  input  logic             sys_reset,
  input  logic             ext_rst_req,
  input  logic             mmcm_locked,
  input  logic             xphy_ready,
  output logic             core_rst,
  output logic             mac_rst,
  output logic             dp_rst,
  output logic             ready,
  output logic             fault,
  output logic [2:0]       seq_state,
  output logic [CNT_W-1:0] reset_count
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int TO_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

  seq_state_e        state, state_nx;
  logic              req_db, abort, phy_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TO_W-1:0]   to_cnt;

  sume_rst_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_req_db (
    .clk  (axis_aclk),
    .rst  (sys_reset),
    .din  (ext_rst_req),
    .dout (req_db)
  );

  assign abort = req_db || !mmcm_locked;

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_HOLD;
    end else begin
      case (state)
        ST_HOLD:     if (hold_cnt == HOLD_LAST) state_nx = ST_REL_CORE;
        ST_REL_CORE: begin
          // A ready PHY at the timeout edge still wins over the fault path.
          if (xphy_ready && gap_cnt == GAP_LAST)      state_nx = ST_REL_MAC;
          else if (!xphy_ready && to_cnt == TO_LAST) state_nx = ST_FAULT;
        end
        ST_REL_MAC: begin
          if (!xphy_ready)                state_nx = ST_REL_CORE;
          else if (gap_cnt == GAP_LAST)   state_nx = ST_RUN;
        end
        ST_RUN:      if (!xphy_ready) state_nx = ST_REL_CORE;
        ST_FAULT:    if (xphy_ready && !phy_q) state_nx = ST_REL_MAC;
        default:     state_nx = ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (sys_reset) state <= ST_HOLD;
    else           state <= state_nx;
  end

  // Saturating counters restart on any state entry and on abort while holding.
  always_ff @(posedge axis_aclk) begin
    if (sys_reset || abort || (state_nx != state)) begin
      hold_cnt <= '0;
      gap_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
      if (gap_cnt != GAP_LAST)   gap_cnt  <= gap_cnt + 1'b1;
      if (to_cnt != TO_LAST)     to_cnt   <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (sys_reset) begin
      core_rst    <= 1'b1;
      mac_rst     <= 1'b1;
      dp_rst      <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      phy_q       <= 1'b0;
      reset_count <= '0;
    end else begin
      core_rst <= (state_nx == ST_HOLD);
      mac_rst  <= (state_nx == ST_HOLD) || (state_nx == ST_REL_CORE) ||
                  (state_nx == ST_FAULT);
      dp_rst   <= (state_nx != ST_RUN);
      ready    <= (state_nx == ST_RUN);
      fault    <= fault || (state_nx == ST_FAULT);
      phy_q    <= xphy_ready;
      if (abort && (state != ST_HOLD) && (reset_count != {CNT_W{1'b1}}))
        reset_count <= reset_count + 1'b1;
    end
  end

  assign seq_state = state;

endmodule

`default_nettype wire

// File: tb/tb_sume_reset_sequencer.sv
// ============================================================
// tb_sume_reset_sequencer: directed + random checks against a timestamp model
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_sume_reset_sequencer;

  localparam int HOLD = 200;
  localparam int GAP  = 16;
  localparam int DEB  = 4;
  localparam int LT   = 1000;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          sys_reset = 1'b1;
  logic          ext_rst_req = 1'b0;
  logic          mmcm_locked = 1'b1;
  logic          xphy_ready = 1'b1;
  logic          core_rst, mac_rst, dp_rst, ready, fault;
  logic [2:0]    seq_state;
  logic [CW-1:0] reset_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: release level (0 held .. 3 running, 4 fault) plus the edge index
  // at which that level was entered; elapsed time is plain subtraction.
  int m_level = 0, m_enter = 0, m_count = 0, m_run = 0, n_edge = 0;
  bit m_fault = 1'b0, m_phy_prev = 1'b0, m_valid = 1'b0;

  always #5 clk = ~clk;

  sume_reset_sequencer #(
    .HOLD_CYCLES  (HOLD),
    .STAGE_GAP    (GAP),
    .DEBOUNCE     (DEB),
    .LOCK_TIMEOUT (LT),
    .CNT_W        (CW)
  ) dut (
    .axis_aclk   (clk),
    .sys_reset   (sys_reset),
    .ext_rst_req (ext_rst_req),
    .mmcm_locked (mmcm_locked),
    .xphy_ready  (xphy_ready),
    .core_rst    (core_rst),
    .mac_rst     (mac_rst),
    .dp_rst      (dp_rst),
    .ready       (ready),
    .fault       (fault),
    .seq_state   (seq_state),
    .reset_count (reset_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin : ref_model
    int lvl, ent, cnt, run, el;
    bit flt, abrt;
    run  = ext_rst_req ? m_run + 1 : 0;
    abrt = (run >= DEB) || !mmcm_locked;
    lvl  = m_level;
    ent  = m_enter;
    cnt  = m_count;
    flt  = m_fault;
    el   = n_edge - m_enter;
    if (sys_reset) begin
      lvl = 0; ent = n_edge; cnt = 0; flt = 1'b0; run = 0;
    end else if (abrt) begin
      if (lvl != 0 && cnt < MAXC) cnt = cnt + 1;
      lvl = 0; ent = n_edge;
    end else begin
      case (lvl)
        0: if (el == HOLD) begin lvl = 1; ent = n_edge; end
        1: begin
          if (xphy_ready && el >= GAP) begin lvl = 2; ent = n_edge; end
          else if (!xphy_ready && el >= LT) begin lvl = 4; ent = n_edge; flt = 1'b1; end
        end
        2: begin
          if (!xphy_ready) begin lvl = 1; ent = n_edge; end
          else if (el >= GAP) begin lvl = 3; ent = n_edge; end
        end
        3: if (!xphy_ready) begin lvl = 1; ent = n_edge; end
        4: if (xphy_ready && !m_phy_prev) begin lvl = 2; ent = n_edge; end
        default: lvl = 0;
      endcase
    end
    m_level    <= lvl;
    m_enter    <= ent;
    m_count    <= cnt;
    m_fault    <= flt;
    m_run      <= run;
    m_phy_prev <= sys_reset ? 1'b0 : xphy_ready;
    n_edge     <= n_edge + 1;
    m_valid    <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("core_rst",    int'(core_rst),    (m_level == 0) ? 1 : 0);
      check("mac_rst",     int'(mac_rst),     (m_level <= 1 || m_level == 4) ? 1 : 0);
      check("dp_rst",      int'(dp_rst),      (m_level != 3) ? 1 : 0);
      check("ready",       int'(ready),       (m_level == 3) ? 1 : 0);
      check("fault",       int'(fault),       int'(m_fault));
      check("seq_state",   int'(seq_state),   m_level);
      check("reset_count", int'(reset_count), m_count);
    end
  end

  initial begin
    // Reset values, then the nominal 200/216/232 release.
    tick(3);
    check("rst_core", int'(core_rst), 1);
    check("rst_ready", int'(ready), 0);
    check("rst_state", int'(seq_state), 0);
    check("rst_count", int'(reset_count), 0);
    sys_reset = 1'b0;
    tick(199); check("nom_core_199", int'(core_rst), 1);
    tick(1);   check("nom_core_200", int'(core_rst), 0);
               check("nom_mac_200", int'(mac_rst), 1);
    tick(15);  check("nom_mac_215", int'(mac_rst), 1);
    tick(1);   check("nom_mac_216", int'(mac_rst), 0);
               check("nom_dp_216", int'(dp_rst), 1);
    tick(15);  check("nom_dp_231", int'(dp_rst), 1);
    tick(1);   check("nom_dp_232", int'(dp_rst), 0);
               check("nom_ready_232", int'(ready), 1);
               check("nom_count", int'(reset_count), 0);

    // Short request ignored, debounced request aborts.
    ext_rst_req = 1'b1; tick(3); ext_rst_req = 1'b0;
    check("req3_ready", int'(ready), 1);
    tick(1);
    ext_rst_req = 1'b1; tick(3);
    check("req4_before", int'(ready), 1);
    tick(1);
    check("req4_core", int'(core_rst), 1);
    check("req4_mac", int'(mac_rst), 1);
    check("req4_dp", int'(dp_rst), 1);
    check("req4_count", int'(reset_count), 1);
    ext_rst_req = 1'b0;
    tick(199); check("req_core_199", int'(core_rst), 1);
    tick(1);   check("req_core_200", int'(core_rst), 0);
    tick(16);  check("req_mac_216", int'(mac_rst), 0);

    // Lock loss in REL_MAC.
    tick(4);
    mmcm_locked = 1'b0; tick(1);
    check("lock_state", int'(seq_state), 0);
    check("lock_core", int'(core_rst), 1);
    check("lock_count", int'(reset_count), 2);
    mmcm_locked = 1'b1;
    tick(199); check("lock_core_199", int'(core_rst), 1);
    tick(1);   check("lock_core_200", int'(core_rst), 0);
    tick(16);  check("lock_mac_216", int'(mac_rst), 0);
    tick(16);  check("lock_ready_232", int'(ready), 1);

    // PHY loss in RUN.
    xphy_ready = 1'b0; tick(1);
    check("phy_mac", int'(mac_rst), 1);
    check("phy_dp", int'(dp_rst), 1);
    check("phy_core", int'(core_rst), 0);
    check("phy_count", int'(reset_count), 2);
    check("phy_state", int'(seq_state), 1);
    xphy_ready = 1'b1;
    tick(15); check("phy_mac_15", int'(mac_rst), 1);
    tick(1);  check("phy_mac_16", int'(mac_rst), 0);
    tick(15); check("phy_dp_31", int'(dp_rst), 1);
    tick(1);  check("phy_dp_32", int'(dp_rst), 0);

    // PHY timeout into FAULT, then recovery.
    sys_reset = 1'b1; xphy_ready = 1'b0; tick(2); sys_reset = 1'b0;
    tick(200); check("to_core_200", int'(core_rst), 0);
    tick(999); check("to_state_1199", int'(seq_state), 1);
               check("to_fault_1199", int'(fault), 0);
    tick(1);   check("to_state_1200", int'(seq_state), 4);
               check("to_fault_1200", int'(fault), 1);
               check("to_core_1200", int'(core_rst), 0);
               check("to_mac_1200", int'(mac_rst), 1);
    xphy_ready = 1'b1; tick(1);
    check("fr_mac", int'(mac_rst), 0);
    tick(15); check("fr_dp_15", int'(dp_rst), 1);
    tick(1);  check("fr_dp_16", int'(dp_rst), 0);
              check("fr_fault", int'(fault), 1);

    // Randomised stretch, checked every cycle by the model.
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(99) < 2) ext_rst_req = 1'b1;
      else if ($urandom_range(3) == 0) ext_rst_req = 1'b0;
      mmcm_locked = ($urandom_range(1999) != 0);
      if ($urandom_range(149) == 0) xphy_ready = ~xphy_ready;
      sys_reset = ($urandom_range(4999) == 0);
      tick(1);
    end

    // Saturate reset_count with debounced requests.
    ext_rst_req = 1'b0; mmcm_locked = 1'b1; xphy_ready = 1'b1;
    sys_reset = 1'b1; tick(2); sys_reset = 1'b0;
    for (int i = 0; i < 260; i++) begin
      tick(200);
      ext_rst_req = 1'b1; tick(4); ext_rst_req = 1'b0;
    end
    tick(200);
    check("sat_count", int'(reset_count), 255);
    tick(19);
    check("sat_state", int'(seq_state), 2);

    // sys_reset mid REL_MAC.
    sys_reset = 1'b1; tick(1);
    check("sr_core", int'(core_rst), 1);
    check("sr_mac", int'(mac_rst), 1);
    check("sr_dp", int'(dp_rst), 1);
    check("sr_ready", int'(ready), 0);
    check("sr_fault", int'(fault), 0);
    check("sr_count", int'(reset_count), 0);
    check("sr_state", int'(seq_state), 0);
    sys_reset = 1'b0;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
